alu_issue_ctrl: RTL and testbench

Operand-fetch, issue and writeback stage that feeds the 3-bit SimpleALU datapath. It accepts instructions over a valid/ready handshake and holds an 8-entry register file. It drives the ALU's Sel/A/B inputs from registered operands, captures the ALU result Q, and writes the result back to the destination register.

---
 rtl/alu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: operand fetch, issue and writeback stage in front of a
// combinational SimpleALU. Instructions come in over a valid/ready handshake.
// Operands are read from an NREGS-entry register file, with forwarding from a
// writeback that is still pending. Operands are registered onto AluSel/AluA/AluB
// and held for one EXEC cycle. AluQ is captured, strobed on Wb*, and then
// written back.
// Optional build macro ALU_ISSUE_FLAGS_EN adds a ZeroFlag output.
module alu_issue_ctrl #(
  parameter int WIDTH = 3,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       InOp,
  input  logic [AW-1:0]    InRd,
  input  logic [AW-1:0]    InRs,
  input  logic [AW-1:0]    InRt,
  input  logic             InImmEn,
  input  logic [WIDTH-1:0] InImm,
  output logic [2:0]       AluSel,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluQ,
  output logic             WbValid,
  output logic [AW-1:0]    WbAddr,
  output logic [WIDTH-1:0] WbData,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic             ZeroFlag,
`endif
  input  logic [AW-1:0]    RdAddr,
  output logic [WIDTH-1:0] RdData
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    rd_q;
  logic             fire;
  logic             fwd_en;
  logic [WIDTH-1:0] opa, opb;

  // Ready depends only on state, so it is high during reset (IDLE).
  assign InReady = (state != EXEC);
  assign fire    = InValid && InReady;

  // Entry 0 is never written, so it always reads back as zero.
  assign RdData  = regs[RdAddr];

  // A writeback is in flight during WB. Its data is not in the file yet, so it is
  // forwarded. Register 0 is excluded because it always reads as zero.
  assign fwd_en  = (state == WB) && (WbAddr != '0);

  // Operand selection with WB->issue forwarding
  always_comb begin
    opa = regs[InRs];
    opb = regs[InRt];
    if (fwd_en && (InRs == WbAddr)) opa = WbData;
    if (fwd_en && (InRt == WbAddr)) opb = WbData;
    if (InImmEn)                    opb = InImm;
  end

  // State register
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode: IDLE -> EXEC -> WB, then WB goes back to EXEC on a fire
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fire) state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      state_n = fire ? EXEC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Issue registers, result capture and register-file write
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      AluSel  <= '0;
      AluA    <= '0;
      AluB    <= '0;
      rd_q    <= '0;
      WbValid <= 1'b0;
      WbAddr  <= '0;
      WbData  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      WbValid <= 1'b0;
      if (fire) begin
        AluSel <= InOp;
        AluA   <= opa;
        AluB   <= opb;
        rd_q   <= InRd;
      end
      if (state == EXEC) begin
        WbData  <= AluQ;
        WbAddr  <= rd_q;
        WbValid <= 1'b1;
      end
      if ((state == WB) && (WbAddr != '0)) regs[WbAddr] <= WbData;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  // Zero flag is captured with each result (including rd=0) and held until the next result
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)            ZeroFlag <= 1'b0;
    else if (state == EXEC) ZeroFlag <= (AluQ == '0);
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. It uses directed vectors with hand-computed
// results. A scoreboard queue is filled at each handshake, and a monitor checks
// every WbValid pulse against that queue. A behavioural SimpleALU drives AluQ.
module tb_alu_issue_ctrl;

  logic       Clk = 0, ResetN = 0;
  logic       InValid = 0, InReady, InImmEn = 0;
  logic [2:0] InOp = 0, InRd = 0, InRs = 0, InRt = 0, InImm = 0;
  logic [2:0] AluSel, AluA, AluB, AluQ;
  logic       WbValid;
  logic [2:0] WbAddr, WbData, RdAddr = 0, RdData;
`ifdef ALU_ISSUE_FLAGS_EN
  logic       ZeroFlag;
`endif

  alu_issue_ctrl dut (
    .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InRd(InRd), .InRs(InRs), .InRt(InRt), .InImmEn(InImmEn),
    .InImm(InImm), .AluSel(AluSel), .AluA(AluA), .AluB(AluB), .AluQ(AluQ),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
`ifdef ALU_ISSUE_FLAGS_EN
    .ZeroFlag(ZeroFlag),
`endif
    .RdAddr(RdAddr), .RdData(RdData)
  );

  always #5 Clk = ~Clk;

  // Behavioural SimpleALU
  always_comb begin
    case (AluSel)
      3'd0: AluQ = 3'd0;
      3'd1: AluQ = AluA + AluB;
      3'd2: AluQ = AluA - AluB;
      3'd3: AluQ = AluA;
      3'd4: AluQ = AluA ^ AluB;
      3'd5: AluQ = AluA | AluB;
      3'd6: AluQ = AluA & AluB;
      default: AluQ = AluA + 3'd1;
    endcase
  end

  typedef struct { logic [2:0] addr; logic [2:0] data; logic zf; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int fire_cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest outstanding issue
  always @(negedge Clk) begin
    if (ResetN && WbValid) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wb_unexpected: got addr=%0d data=%0d expected no writeback", WbAddr, WbData);
      end else begin
        e = q.pop_front();
        chk("wb_addr", WbAddr, e.addr);
        chk("wb_data", WbData, e.data);
`ifdef ALU_ISSUE_FLAGS_EN
        chk("zero_flag", ZeroFlag, e.zf);
`endif
      end
    end
  end

  // Present an instruction and hold it until the handshake fires. Then push its expected result.
  task automatic issue(input logic [2:0] op, rd, rs, rt, input logic imm_en,
                       input logic [2:0] imm, input logic [2:0] exp_d, input logic exp_z);
    exp_t e;
    bit fired = 0;
    @(negedge Clk);
    InValid = 1; InOp = op; InRd = rd; InRs = rs; InRt = rt; InImmEn = imm_en; InImm = imm;
    for (int n = 0; n < 20 && !fired; n++) begin
      if (InReady) fired = 1;
      @(posedge Clk);
      if (!fired) @(negedge Clk);
    end
    if (!fired) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got InReady=0 for 20 cycles expected handshake");
    end else begin
      fire_cyc = cyc;
      e.addr = rd; e.data = exp_d; e.zf = exp_z;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge Clk);
    InValid = 0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [2:0] exp);
    RdAddr = a; #1;
    chk($sformatf("rd_data[%0d]", a), RdData, exp);
  endtask

  int t0, t1, t2;

  initial begin
    // 1. reset state
    #12;
    for (int i = 0; i < 8; i++) rd_chk(i[2:0], 3'd0);
    chk("reset_in_ready", InReady, 1);
    chk("reset_wb_valid", WbValid, 0);
    chk("reset_alu_sel", AluSel, 0);
    chk("reset_alu_a", AluA, 0);
    chk("reset_alu_b", AluB, 0);
    @(negedge Clk); ResetN = 1;

    // 2. immediate loads: r1=5, r2=2
    issue(3'd1, 3'd1, 3'd0, 3'd0, 1, 3'd5, 3'd5, 0);
    issue(3'd1, 3'd2, 3'd0, 3'd0, 1, 3'd2, 3'd2, 0);
    idle(3);
    rd_chk(3'd1, 3'd5);
    rd_chk(3'd2, 3'd2);

    // 3. register ops with r1=5, r2=2
    issue(3'd2, 3'd3, 3'd1, 3'd2, 0, 3'd0, 3'd3, 0); // sub 5-2
    issue(3'd4, 3'd4, 3'd1, 3'd2, 0, 3'd0, 3'd7, 0); // xor
    issue(3'd6, 3'd5, 3'd1, 3'd2, 0, 3'd0, 3'd0, 1); // and -> zero
    issue(3'd5, 3'd6, 3'd1, 3'd2, 0, 3'd0, 3'd7, 0); // or
    idle(3);
    rd_chk(3'd3, 3'd3);
    rd_chk(3'd4, 3'd7);
    rd_chk(3'd5, 3'd0);
    rd_chk(3'd6, 3'd7);

    // 4. back-to-back forwarding chain on r4
    issue(3'd1, 3'd4, 3'd0, 3'd0, 1, 3'd6, 3'd6, 0); t0 = fire_cyc;
    issue(3'd7, 3'd4, 3'd4, 3'd0, 0, 3'd0, 3'd7, 0); t1 = fire_cyc;
    issue(3'd7, 3'd4, 3'd4, 3'd0, 0, 3'd0, 3'd0, 1); t2 = fire_cyc;
    chk("fire_spacing_1", t1 - t0, 2);
    chk("fire_spacing_2", t2 - t1, 2);
    idle(3);
    rd_chk(3'd4, 3'd0);

    // 5. borrow wrap 2-5=5, then write to r0
    issue(3'd2, 3'd5, 3'd2, 3'd1, 0, 3'd0, 3'd5, 0);
    issue(3'd1, 3'd0, 3'd0, 3'd0, 1, 3'd6, 3'd6, 0);
    idle(3);
    rd_chk(3'd5, 3'd5);
    rd_chk(3'd0, 3'd0);
    chk("queue_drained", q.size(), 0);

    // 6. reset during EXEC aborts the instruction
    issue(3'd1, 3'd6, 3'd0, 3'd0, 1, 3'd3, 3'd3, 0);
    void'(q.pop_back()); // the aborted result must never appear
    #2 ResetN = 0; InValid = 0;
    @(negedge Clk);
    chk("rst_wb_valid", WbValid, 0);
    chk("rst_in_ready", InReady, 1);
    chk("rst_alu_sel", AluSel, 0);
    ResetN = 1;
    repeat (4) @(negedge Clk);
    chk("post_rst_in_ready", InReady, 1);
    rd_chk(3'd6, 3'd0);
    rd_chk(3'd1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "timeout");
  end

endmodule
